// File: rtl/mux8t1_32.sv
// Registered 8:1 word select: one-cycle latency, captures only when in_valid, no backpressure.
// Define MUX8T1_32_PARITY_EN to add O_par, the registered even parity of O0.
module mux8t1_32 #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [2:0]       S,
  input  logic             in_valid,
  output logic [WIDTH-1:0] O0,
  output logic [2:0]       S_q,
  output logic             out_valid
`ifdef MUX8T1_32_PARITY_EN
  ,
  output logic             O_par
`endif
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] data_d, data_q;
  logic [2:0]       sel_d, sel_q;
  logic             vld_d, vld_q;

  always_comb begin
    sel = I0;
    case (S)
      3'd0: sel = I0;
      3'd1: sel = I1;
      3'd2: sel = I2;
      3'd3: sel = I3;
      3'd4: sel = I4;
      3'd5: sel = I5;
      3'd6: sel = I6;
      3'd7: sel = I7;
      default: sel = I0;
    endcase
  end

  // Word and select hold while idle; the valid strobe is a single-cycle pulse.
  always_comb begin
    data_d = in_valid ? sel : data_q;
    sel_d  = in_valid ? S   : sel_q;
    vld_d  = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      sel_q  <= 3'd0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  assign O0        = data_q;
  assign S_q       = sel_q;
  assign out_valid = vld_q;

`ifdef MUX8T1_32_PARITY_EN
  logic par_d, par_q;

  // Parity is computed from the pre-register word so it tracks O0 with no extra delay.
  always_comb begin
    par_d = in_valid ? ^sel : par_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= ^RST_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign O_par = par_q;
`endif

endmodule

// File: tb/tb_mux8t1_32.sv
// Bench for mux8t1_32: vector table, hand-written reset sequences, randomized model comparison.
module tb_mux8t1_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] din [8];
  logic [2:0]  s;
  logic        in_valid;
  logic [31:0] o0;
  logic [2:0]  s_q;
  logic        out_valid;
`ifdef MUX8T1_32_PARITY_EN
  logic        o_par;
`endif

  int checks;
  int failures;

  mux8t1_32 #(.WIDTH(32), .RST_VAL(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I0       (din[0]),
    .I1       (din[1]),
    .I2       (din[2]),
    .I3       (din[3]),
    .I4       (din[4]),
    .I5       (din[5]),
    .I6       (din[6]),
    .I7       (din[7]),
    .S        (s),
    .in_valid (in_valid),
    .O0       (o0),
    .S_q      (s_q),
    .out_valid(out_valid)
`ifdef MUX8T1_32_PARITY_EN
    ,
    .O_par    (o_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  s;
    logic        vld;
    logic [31:0] exp_o;
    logic [2:0]  exp_s;
    logic        exp_v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] eo, input logic [2:0] es,
                         input logic ev);
    chk({name, ".O0"}, o0, eo);
    chk({name, ".S_q"}, {29'd0, s_q}, {29'd0, es});
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
`ifdef MUX8T1_32_PARITY_EN
    chk({name, ".O_par"}, {31'd0, o_par}, {31'd0, ^eo});
`endif
  endtask

  vec_t        vecs [11];
  logic [31:0] m_o;
  logic [2:0]  m_s;
  logic        m_v;

  initial begin
    checks   = 0;
    failures = 0;
    in_valid = 1'b0;
    s        = 3'd0;
    for (int i = 0; i < 8; i++) din[i] = 32'(i);

    // Reset asserted between clock edges must clear the outputs at once.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_out("reset_async", 32'h0, 3'd0, 1'b0);
    in_valid = 1'b1;
    s        = 3'd4;
    step();
    chk_out("reset_hold", 32'h0, 3'd0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // Sweep S=0..7 back-to-back, then hold with S changing while idle.
    for (int i = 0; i < 8; i++) vecs[i] = '{3'(i), 1'b1, 32'(i), 3'(i), 1'b1};
    vecs[8]  = '{3'd5, 1'b1, 32'd5, 3'd5, 1'b1};
    vecs[9]  = '{3'd1, 1'b0, 32'd5, 3'd5, 1'b0};
    vecs[10] = '{3'd2, 1'b0, 32'd5, 3'd5, 1'b0};
    for (int i = 0; i < 11; i++) begin
      s        = vecs[i].s;
      in_valid = vecs[i].vld;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_s, vecs[i].exp_v);
    end

    // Bit-exact data patterns and a single-bit odd-parity word.
    din[3] = 32'hFFFF_FFFF;
    din[6] = 32'hA5A5_5A5A;
    din[2] = 32'h0000_0001;
    in_valid = 1'b1;
    s = 3'd3; step(); chk_out("pat_ones", 32'hFFFF_FFFF, 3'd3, 1'b1);
    s = 3'd6; step(); chk_out("pat_a5", 32'hA5A5_5A5A, 3'd6, 1'b1);
    s = 3'd2; step(); chk_out("par_one", 32'h0000_0001, 3'd2, 1'b1);
`ifdef MUX8T1_32_PARITY_EN
    chk("par_one_bit", {31'd0, o_par}, 32'd1);
`endif

    // Reset pulse in the middle of a valid stream, then recovery.
    s = 3'd7; step(); chk_out("stream_a", 32'd7, 3'd7, 1'b1);
    s = 3'd6;
    #3 rst_n = 1'b0;
    #1 chk_out("mid_reset", 32'h0, 3'd0, 1'b0);
    step();
    chk_out("mid_reset_hold", 32'h0, 3'd0, 1'b0);
    #2 rst_n = 1'b1;
    s = 3'd4;
    step();
    chk_out("post_reset", 32'd4, 3'd4, 1'b1);

    // Randomized traffic against a model: the output word is simply the last selected word.
    m_o = 32'd4; m_s = 3'd4; m_v = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) din[i] = $urandom;
      s        = 3'($urandom_range(0, 7));
      in_valid = (n == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (in_valid) begin
        m_o = din[s];
        m_s = s;
      end
      m_v = in_valid;
      step();
      chk_out($sformatf("rand%0d", n), m_o, m_s, m_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
